// File: rtl/barycentric_interp.sv
// Barycentric attribute interpolator: attr = u*A + v*B + w*C per component,
// three-stage valid/ready pipeline with global stall, rounding and saturation.
module barycentric_interp #(
   parameter int unsigned COORD_WIDTH = 32,
   parameter int unsigned ATTR_WIDTH  = 16,
   parameter int unsigned NUM_ATTR    = 3
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 load,
   input  logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0]  attr_a,
   input  logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0]  attr_b,
   input  logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0]  attr_c,
   input  logic [COORD_WIDTH-1:0]               u,
   input  logic [COORD_WIDTH-1:0]               v,
   input  logic [COORD_WIDTH-1:0]               w,
   input  logic                                 valid_in,
   output logic                                 ready_in,
   output logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0]  attr_out,
   output logic                                 sat_out,
   output logic                                 valid_out,
   input  logic                                 ready_out,
   output logic                                 loaded
);

   localparam int unsigned FRAC = COORD_WIDTH / 2;
   localparam int unsigned PW   = ATTR_WIDTH + COORD_WIDTH;
   localparam int unsigned SW   = PW + 2;

   localparam logic signed [SW-1:0] ROUND_BIAS = SW'(64'd1 << (FRAC - 1));
   localparam logic signed [SW-1:0] ATTR_MAX   = SW'((64'd1 << (ATTR_WIDTH - 1)) - 64'd1);
   localparam logic signed [SW-1:0] ATTR_MIN   = ~ATTR_MAX;

   typedef enum logic {
      ST_UNLOADED,
      ST_LOADED
   } state_t;

   state_t state;

   logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0] a_q;
   logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0] b_q;
   logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0] c_q;

   logic                 s1_valid;
   logic                 s2_valid;
   logic signed [PW-1:0] s1_pa [NUM_ATTR];
   logic signed [PW-1:0] s1_pb [NUM_ATTR];
   logic signed [PW-1:0] s1_pc [NUM_ATTR];
   logic signed [SW-1:0] s2_sum [NUM_ATTR];

   logic signed [SW-1:0]                rnd_c [NUM_ATTR];
   logic [NUM_ATTR-1:0][ATTR_WIDTH-1:0] nxt_attr;
   logic                                nxt_sat;

   logic stall;
   logic accept;

   // Handshake: a stalled output freezes the whole pipe; load blocks new samples
   assign loaded   = (state == ST_LOADED);
   assign stall    = valid_out && !ready_out;
   assign ready_in = loaded && !stall && !load;
   assign accept   = valid_in && ready_in;

   // Round half toward +inf, drop the fraction, clamp to the attribute range
   always_comb begin
      nxt_attr = '0;
      nxt_sat  = 1'b0;
      for (int k = 0; k < NUM_ATTR; k++) begin
         rnd_c[k] = (s2_sum[k] + ROUND_BIAS) >>> FRAC;
         if (rnd_c[k] > ATTR_MAX) begin
            nxt_attr[k] = ATTR_MAX[ATTR_WIDTH-1:0];
            nxt_sat     = 1'b1;
         end else if (rnd_c[k] < ATTR_MIN) begin
            nxt_attr[k] = ATTR_MIN[ATTR_WIDTH-1:0];
            nxt_sat     = 1'b1;
         end else begin
            nxt_attr[k] = rnd_c[k][ATTR_WIDTH-1:0];
         end
      end
   end

   // Load state, vertex attribute latch and stage valids (load flushes the pipe)
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state     <= ST_UNLOADED;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         valid_out <= 1'b0;
      end else if (load) begin
         state     <= ST_LOADED;
         a_q       <= attr_a;
         b_q       <= attr_b;
         c_q       <= attr_c;
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         valid_out <= 1'b0;
      end else if (!stall) begin
         s1_valid  <= accept;
         s2_valid  <= s1_valid;
         valid_out <= s2_valid;
      end
   end

   // Datapath: products, per-component sum, rounded/saturated result
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int k = 0; k < NUM_ATTR; k++) begin
            s1_pa[k]  <= '0;
            s1_pb[k]  <= '0;
            s1_pc[k]  <= '0;
            s2_sum[k] <= '0;
         end
         attr_out <= '0;
         sat_out  <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < NUM_ATTR; k++) begin
            s1_pa[k]  <= PW'($signed(u)) * PW'($signed(a_q[k]));
            s1_pb[k]  <= PW'($signed(v)) * PW'($signed(b_q[k]));
            s1_pc[k]  <= PW'($signed(w)) * PW'($signed(c_q[k]));
            s2_sum[k] <= SW'(s1_pa[k]) + SW'(s1_pb[k]) + SW'(s1_pc[k]);
         end
         attr_out <= nxt_attr;
         sat_out  <= nxt_sat;
      end
   end

endmodule

// File: tb/tb_barycentric_interp.sv
// Bench for barycentric_interp: directed cases plus randomized traffic,
// scored every cycle against a queue-based model of the interpolator.
module tb_barycentric_interp;

   typedef logic [2:0][15:0] vec_t;

   typedef struct packed {
      logic sat;
      vec_t attr;
   } res_t;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        load;
   vec_t        attr_a, attr_b, attr_c;
   logic [31:0] u, v, w;
   logic        valid_in;
   logic        ready_in;
   vec_t        attr_out;
   logic        sat_out;
   logic        valid_out;
   logic        ready_out;
   logic        loaded;

   always #5 clk_in = ~clk_in;

   barycentric_interp dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .load      (load),
      .attr_a    (attr_a),
      .attr_b    (attr_b),
      .attr_c    (attr_c),
      .u         (u),
      .v         (v),
      .w         (w),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .attr_out  (attr_out),
      .sat_out   (sat_out),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .loaded    (loaded)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer interpolation with round-half-up and clamp
   function automatic res_t interp(input int a[3], input int b[3], input int c[3],
                                   input int uu, input int vv, input int ww);
      res_t r;
      r = '0;
      for (int k = 0; k < 3; k++) begin
         longint s;
         longint q;
         s = longint'(uu) * longint'(a[k]) + longint'(vv) * longint'(b[k])
           + longint'(ww) * longint'(c[k]);
         q = (s + 64'sd32768) >>> 16;
         if (q > 32767) begin
            q = 32767;
            r.sat = 1'b1;
         end else if (q < -32768) begin
            q = -32768;
            r.sat = 1'b1;
         end
         r.attr[k] = q[15:0];
      end
      return r;
   endfunction

   // Model: each accepted sample waits for three unstalled edges, then is shown
   int   la[3], lb[3], lc[3];
   bit   loaded_m;
   res_t q_res[$];
   int   q_age[$];
   bit   model_ok   = 1'b0;
   bit   just_reset = 1'b0;
   int   n_consumed = 0;
   bit   vexp, stall_m, rdy_m, acc_m;

   always @(negedge clk_in) begin
      if (model_ok) begin
         vexp    = (q_res.size() > 0) && (q_age[0] == 3);
         stall_m = vexp && !ready_out;
         rdy_m   = loaded_m && !stall_m && !load;
         chk("valid_out", longint'(valid_out), longint'(vexp));
         chk("loaded", longint'(loaded), longint'(loaded_m));
         chk("ready_in", longint'(ready_in), longint'(rdy_m));
         if (vexp) begin
            for (int k = 0; k < 3; k++)
               chk("attr_out", longint'($signed(attr_out[k])), longint'($signed(q_res[0].attr[k])));
            chk("sat_out", longint'(sat_out), longint'(q_res[0].sat));
         end
         if (just_reset) begin
            chk("reset_attr_out", longint'(attr_out), 0);
            chk("reset_sat_out", longint'(sat_out), 0);
         end
         if (valid_out && ready_out) n_consumed++;
      end
      just_reset = 1'b0;
      if (!rst_in) begin
         model_ok   = 1'b1;
         just_reset = 1'b1;
         loaded_m   = 1'b0;
         q_res.delete();
         q_age.delete();
         for (int k = 0; k < 3; k++) begin
            la[k] = 0; lb[k] = 0; lc[k] = 0;
         end
      end else if (model_ok) begin
         acc_m = valid_in && rdy_m;
         if (load) begin
            for (int k = 0; k < 3; k++) begin
               la[k] = int'($signed(attr_a[k]));
               lb[k] = int'($signed(attr_b[k]));
               lc[k] = int'($signed(attr_c[k]));
            end
            loaded_m = 1'b1;
            q_res.delete();
            q_age.delete();
         end else if (!stall_m) begin
            if (vexp) begin
               void'(q_res.pop_front());
               void'(q_age.pop_front());
            end
            foreach (q_age[i]) q_age[i]++;
            if (acc_m) begin
               q_res.push_back(interp(la, lb, lc, int'($signed(u)), int'($signed(v)), int'($signed(w))));
               q_age.push_back(1);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_load(input vec_t a, input vec_t b, input vec_t c);
      attr_a = a; attr_b = b; attr_c = c;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Present one sample and hold it until the block takes it
   task automatic send(input logic [31:0] uu, input logic [31:0] vv, input logic [31:0] ww);
      bit done;
      done = 1'b0;
      valid_in = 1'b1;
      u = uu; v = vv; w = ww;
      for (int t = 0; t < 50 && !done; t++) begin
         #1;
         done = ready_in;
         step();
      end
      valid_in = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got ready_in=0 for 50 cycles, expected acceptance");
      end
   endtask

   task automatic drain();
      valid_in  = 1'b0;
      ready_out = 1'b1;
      repeat (6) step();
   endtask

   task automatic rand_weights();
      int mode;
      int uu, vv;
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
         uu = int'($urandom_range(0, 65536));
         vv = int'($urandom_range(0, 65536 - uu));
         u = 32'(uu); v = 32'(vv); w = 32'(65536 - uu - vv);
      end else if (mode == 1) begin
         u = 32'($urandom_range(0, 196608)) - 32'h0001_0000;
         v = 32'($urandom_range(0, 196608)) - 32'h0001_0000;
         w = 32'($urandom_range(0, 196608)) - 32'h0001_0000;
      end else begin
         u = $urandom; v = $urandom; w = $urandom;
      end
   endtask

   function automatic vec_t rand_vec();
      return {16'($urandom), 16'($urandom), 16'($urandom)};
   endfunction

   initial begin
      int   lat;
      int   idx;
      int   n0;
      bit   acc;
      int   ta[3], tb[3], tc[3];
      res_t r;

      rst_in = 1'b0; load = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
      attr_a = '0; attr_b = '0; attr_c = '0; u = '0; v = '0; w = '0;
      step();
      step();
      rst_in = 1'b1;
      step();

      // Pin the reference model with hand-worked results
      ta = '{100, 0, 0}; tb = '{0, 200, 0}; tc = '{0, 0, 300};
      r = interp(ta, tb, tc, 65536, 0, 0);
      chk("model_unit_u", longint'($signed(r.attr[0])), 100);
      ta = '{1, 0, 0}; tb = '{2, 0, 0}; tc = '{0, 0, 0};
      r = interp(ta, tb, tc, 32768, 32768, 0);
      chk("model_round_pos", longint'($signed(r.attr[0])), 2);
      ta = '{-1, 0, 0}; tb = '{-2, 0, 0};
      r = interp(ta, tb, tc, 32768, 32768, 0);
      chk("model_round_neg", longint'($signed(r.attr[0])), -1);
      ta = '{32767, 0, 0};
      r = interp(ta, tb, tc, 131072, 0, 0);
      chk("model_sat_hi", longint'($signed(r.attr[0])), 32767);
      chk("model_sat_hi_flag", longint'(r.sat), 1);

      // Valid before load is ignored
      valid_in = 1'b1; u = 32'h0001_0000;
      repeat (4) step();
      chk("preload_ready_in", longint'(ready_in), 0);
      valid_in = 1'b0;

      // Unit weight on vertex A, latency and literal result
      do_load({16'd0, 16'd0, 16'd100}, {16'd0, 16'd200, 16'd0}, {16'd300, 16'd0, 16'd0});
      valid_in = 1'b1; u = 32'h0001_0000; v = '0; w = '0;
      step();
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 20) begin
         step();
         lat++;
      end
      chk("latency", lat, 3);
      chk("t1_attr0", longint'($signed(attr_out[0])), 100);
      chk("t1_attr1", longint'($signed(attr_out[1])), 0);
      chk("t1_attr2", longint'($signed(attr_out[2])), 0);
      chk("t1_sat", longint'(sat_out), 0);
      drain();

      // Rounding cases
      do_load({16'd0, 16'd0, 16'd1}, {16'd0, 16'd0, 16'd2}, '0);
      send(32'h8000, 32'h8000, 0);
      do_load({16'd0, 16'd0, 16'hFFFF}, {16'd0, 16'd0, 16'hFFFE}, '0);
      send(32'h8000, 32'h8000, 0);
      drain();
      do_load({16'd0, 16'd0, 16'd100}, {16'd0, 16'd0, 16'd200}, '0);
      send(32'h8000, 32'h8000, 0);
      drain();

      // Saturation both ways
      do_load({16'd0, 16'd0, 16'd32767}, '0, '0);
      send(32'h0002_0000, 0, 0);
      drain();
      do_load({16'd0, 16'd0, 16'h8000}, '0, '0);
      send(32'h0002_0000, 0, 0);
      drain();

      // Backpressure: eight samples, ready_out low for four cycles mid-stream
      do_load({16'd7, 16'hFFCE, 16'd100}, {16'd1000, 16'd3, 16'hFC18}, {16'd5, 16'd500, 16'd9});
      n0 = n_consumed; idx = 0;
      for (int c = 0; c < 40; c++) begin
         ready_out = !(c >= 6 && c < 10);
         valid_in  = (idx < 8);
         u = 32'(idx * 32'h2000); v = 32'h0001_0000 - u; w = 32'(idx * 32'h100);
         #1;
         acc = valid_in && ready_in;
         step();
         if (acc) idx++;
      end
      drain();
      chk("bp_count", n_consumed - n0, 8);

      // Load mid-stream flushes in-flight samples; the next one uses new attrs
      valid_in = 1'b1; u = 32'h0000_4000; v = 32'h0000_C000; w = 0;
      step();
      step();
      attr_a = {16'd11, 16'd22, 16'd33}; attr_b = {16'd44, 16'd55, 16'd66}; attr_c = '0;
      load = 1'b1;
      step();
      load = 1'b0; valid_in = 1'b0;
      send(32'h0001_0000, 0, 0);
      drain();

      // Reset with samples in flight
      valid_in = 1'b1;
      step(); step(); step();
      valid_in = 1'b0;
      rst_in = 1'b0;
      step();
      chk("rst_valid_out", longint'(valid_out), 0);
      chk("rst_loaded", longint'(loaded), 0);
      rst_in = 1'b1;
      repeat (4) step();
      do_load(rand_vec(), rand_vec(), rand_vec());
      send(32'h0000_8000, 32'h0000_4000, 32'h0000_4000);
      drain();

      // Randomized traffic
      do_load(rand_vec(), rand_vec(), rand_vec());
      for (int c = 0; c < 1500; c++) begin
         rst_in    = ($urandom_range(0, 299) != 0);
         load      = ($urandom_range(0, 59) == 0);
         if (load) begin
            attr_a = rand_vec(); attr_b = rand_vec(); attr_c = rand_vec();
         end
         valid_in  = ($urandom_range(0, 9) < 7);
         ready_out = ($urandom_range(0, 3) != 0);
         rand_weights();
         step();
      end
      rst_in = 1'b1; load = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
